bit_reversal_seq_ctrl: RTL and testbench
========================================

Name: bit_reversal_seq_ctrl

Overview:
- FSM that sequences the registered bit-reversal permutation datapath over a programmable chain of passes, one pass per NTT stage.
- It drives the datapath's step code, input-mux select and register enables. Pass k's output is fed back as pass k+1's input, so one permutation instance serves all stages.
- It sits between the NTT top-level controller (start/result handshake) and the SIZE x WIDTH permutation datapath; it carries no data itself.

Parameters:
- STEP_W, 3, width of the per-pass step code sent to the permutation unit.
- MAX_PASSES, 8, maximum passes per job; the pass-count port is clog2(MAX_PASSES)+1 bits wide.
- STEP_INC, 1, amount added to the step code after each pass (modulo 2^STEP_W).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request, sampled only in IDLE.
- num_passes  in  clog2(MAX_PASSES)+1  passes for this job, latched on accepted start.
- first_step  in  STEP_W  step code of pass 0, latched on accepted start.
- abort  in  1  synchronous cancel, highest priority after reset.
- busy  out  1  high from the accepted start until the job ends (result taken, or abort).
- dp_sel_fb  out  1  datapath input mux: 0 = external vector, 1 = feedback from output register.
- dp_in_en  out  1  load enable of the datapath input register (vector and step).
- dp_out_en  out  1  load enable of the datapath output register.
- dp_step  out  STEP_W  step code presented with dp_in_en.
- pass_idx  out  clog2(MAX_PASSES)  index of the pass in flight.
- out_valid  out  1  result in datapath output register is final.
- out_ready  in  1  consumer accepts the result.
- err_len  out  1  one-cycle pulse: start rejected because num_passes > MAX_PASSES.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - busy, dp_sel_fb, dp_in_en, dp_out_en, out_valid, err_len = 0.
  - dp_step = 0, pass_idx = 0.
- States: IDLE, LOAD, EVAL, DONE. Every output is registered.
- IDLE:
  - start with 1 <= num_passes <= MAX_PASSES: latch num_passes and first_step, set busy, go to LOAD.
  - start with num_passes == 0: pulse out_valid for one cycle, no enables, stay IDLE.
  - start with num_passes > MAX_PASSES: pulse err_len, stay IDLE.
- LOAD (one cycle): dp_in_en = 1, dp_sel_fb = 0 for pass 0, otherwise 1; dp_step = current step. Next state EVAL.
- EVAL (one cycle): dp_out_en = 1, dp_in_en = 0.
  - If pass_idx == num_passes-1: go to DONE.
  - Otherwise: pass_idx += 1, step += STEP_INC (wraps mod 2^STEP_W), go to LOAD.
- Cost: 2 cycles per pass. out_valid rises exactly 1 + 2*num_passes cycles after the accepted-start edge.
- DONE:
  - out_valid = 1 and all enables 0, so the output register holds.
  - out_valid & out_ready: go to IDLE next cycle, clear busy and out_valid, pass_idx = 0.
- start is ignored in any state other than IDLE; no queuing.
- abort in LOAD, EVAL or DONE: go to IDLE next cycle.
  - All outputs return to reset values; no out_valid pulse.
  - Datapath contents are don't-care after abort.
- abort and out_ready asserted together in DONE: abort wins, no completion.
- abort in IDLE: no effect; a start in the same cycle is dropped.
- Reset asserted mid-job: immediate return to the reset values above.

Decomposition:
- Package bit_reversal_pkg:
  - state enum type (IDLE/LOAD/EVAL/DONE, 2-bit).
  - PASS_W = clog2(MAX_PASSES)+1 helper function.
  - default STEP_W.
- No sub-module. Single FSM plus pass and step counters, about 150 RTL lines.
- Bench-only wrapper instantiates this controller with the registered permutation datapath (WIDTH=32, SIZE=257) for end-to-end checks.

Test Plan:
- Reset, then start, num_passes=3, first_step=2, out_ready=1.
  - dp_in_en high at cycles 1, 3, 5 with dp_step 2, 3, 4.
  - dp_sel_fb = 0, 1, 1 on those cycles.
  - out_valid high at cycle 7, busy low at cycle 8.
- num_passes=8, first_step=7, STEP_INC=1: dp_step wraps 7, 0, 1, …, 6; pass_idx reaches 7; out_valid at cycle 17.
- Back-pressure: num_passes=1, out_ready=0 for 10 cycles.
  - out_valid held, dp_out_en stays 0, second start ignored.
  - out_ready=1 returns to IDLE next cycle.
- num_passes=0: out_valid pulses for 1 cycle, busy stays 0. num_passes=9: err_len pulses, busy stays 0.
- abort during EVAL of pass 2 of 4: next cycle all outputs zero, no out_valid; a fresh start completes correctly.
- End-to-end with datapath: random 257x32 vector, 2 passes = composition of two reference-model permutations. Asynchronous rst_n pulse mid-pass clears outputs within the same cycle.

Source files
------------

// File: rtl/bit_reversal_pkg.sv
// Shared types and sizing helpers for the bit-reversal pass sequencer.
package bit_reversal_pkg;

    localparam int STEP_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Pass-count width: enough to hold MAX_PASSES itself, not just MAX_PASSES-1.
    function automatic int pass_w(input int max_passes);
        return $clog2(max_passes) + 1;
    endfunction

endpackage

// File: rtl/bit_reversal_seq_ctrl.sv
// Sequences the registered permutation datapath over a chain of passes,
// feeding each pass's output register back as the next pass's input.
//
// state | meaning
// IDLE  | waiting for start; zero-length and over-length requests answered here
// LOAD  | load datapath input register (external vector on pass 0, feedback after)
// EVAL  | load datapath output register; advance pass/step or finish
// DONE  | result final in output register, held until out_ready
module bit_reversal_seq_ctrl
    import bit_reversal_pkg::*;
#(
    parameter int STEP_W     = STEP_W_DEF,
    parameter int MAX_PASSES = 8,
    parameter int STEP_INC   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [pass_w(MAX_PASSES)-1:0] num_passes,
    input  logic [STEP_W-1:0]             first_step,
    input  logic                          abort,
    output logic                          busy,
    output logic                          dp_sel_fb,
    output logic                          dp_in_en,
    output logic                          dp_out_en,
    output logic [STEP_W-1:0]             dp_step,
    output logic [pass_w(MAX_PASSES)-2:0] pass_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err_len
);

    localparam int PASS_W = pass_w(MAX_PASSES);
    localparam int IDX_W  = PASS_W - 1;

    state_e              state_q, state_d;
    logic [PASS_W-1:0]   num_q, num_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [IDX_W-1:0]    pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                sel_fb_q, sel_fb_d;
    logic                in_en_q, in_en_d;
    logic                out_en_q, out_en_d;
    logic [STEP_W-1:0]   dp_step_q, dp_step_d;
    logic                out_valid_q, out_valid_d;
    logic                err_len_q, err_len_d;
    logic                last_pass;

    assign last_pass = ({1'b0, pass_q} == (num_q - PASS_W'(1)));

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        step_d      = step_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        sel_fb_d    = 1'b0;
        in_en_d     = 1'b0;
        out_en_d    = 1'b0;
        dp_step_d   = dp_step_q;
        out_valid_d = 1'b0;
        err_len_d   = 1'b0;

        // Abort in IDLE simply drops any start: pulses and enables default to 0.
        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                pass_d    = '0;
                step_d    = '0;
                dp_step_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_passes == '0) begin
                            out_valid_d = 1'b1;
                        end else if (num_passes > PASS_W'(MAX_PASSES)) begin
                            err_len_d = 1'b1;
                        end else begin
                            num_d   = num_passes;
                            step_d  = first_step;
                            pass_d  = '0;
                            busy_d  = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    in_en_d   = 1'b1;
                    sel_fb_d  = (pass_q != '0);
                    dp_step_d = step_q;
                    state_d   = ST_EVAL;
                end
                ST_EVAL: begin
                    out_en_d = 1'b1;
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d  = pass_q + IDX_W'(1);
                        step_d  = step_q + STEP_W'(STEP_INC);
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        pass_d    = '0;
                        dp_step_d = '0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            step_q      <= '0;
            pass_q      <= '0;
            busy_q      <= 1'b0;
            sel_fb_q    <= 1'b0;
            in_en_q     <= 1'b0;
            out_en_q    <= 1'b0;
            dp_step_q   <= '0;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            step_q      <= step_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            sel_fb_q    <= sel_fb_d;
            in_en_q     <= in_en_d;
            out_en_q    <= out_en_d;
            dp_step_q   <= dp_step_d;
            out_valid_q <= out_valid_d;
            err_len_q   <= err_len_d;
        end
    end

    assign busy      = busy_q;
    assign dp_sel_fb = sel_fb_q;
    assign dp_in_en  = in_en_q;
    assign dp_out_en = out_en_q;
    assign dp_step   = dp_step_q;
    assign pass_idx  = pass_q;
    assign out_valid = out_valid_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_bit_reversal_seq_ctrl.sv
// Bench for the pass sequencer, with a behavioural 257x32 registered datapath
// driven by the controller's enables for end-to-end checks.
module tb_bit_reversal_seq_ctrl;

    localparam int SIZE = 257;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_passes = '0;
    logic [2:0]  first_step = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, dp_sel_fb, dp_in_en, dp_out_en, out_valid, err_len;
    logic [2:0]  dp_step;
    logic [2:0]  pass_idx;

    always #5 clk = ~clk;

    bit_reversal_seq_ctrl #(.STEP_W(3), .MAX_PASSES(8), .STEP_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
        .first_step(first_step), .abort(abort), .busy(busy), .dp_sel_fb(dp_sel_fb),
        .dp_in_en(dp_in_en), .dp_out_en(dp_out_en), .dp_step(dp_step),
        .pass_idx(pass_idx), .out_valid(out_valid), .out_ready(out_ready),
        .err_len(err_len)
    );

    typedef struct packed {
        logic       busy;
        logic       sel_fb;
        logic       in_en;
        logic       out_en;
        logic [2:0] step;
        logic [2:0] pidx;
        logic       ov;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stand-in permutation: gather from index i*(2*step+3) mod 257 (bijective, 257 prime).
    logic [31:0] ext_vec [SIZE];
    logic [31:0] dp_in   [SIZE];
    logic [31:0] dp_out  [SIZE];
    logic [31:0] exp_vec [SIZE];
    logic [31:0] tmp_vec [SIZE];
    logic [2:0]  dp_in_step;

    function automatic int src_idx(input int i, input logic [2:0] s);
        return (i * (2 * int'(s) + 3)) % SIZE;
    endfunction

    always @(posedge clk) begin
        if (dp_in_en) begin
            for (int i = 0; i < SIZE; i++) dp_in[i] <= dp_sel_fb ? dp_out[i] : ext_vec[i];
            dp_in_step <= dp_step;
        end
        if (dp_out_en) begin
            for (int i = 0; i < SIZE; i++) dp_out[i] <= dp_in[src_idx(i, dp_in_step)];
        end
    end

    function automatic obs_t sample_dut();
        obs_t o;
        o.busy   = busy;
        o.sel_fb = dp_sel_fb;
        o.in_en  = dp_in_en;
        o.out_en = dp_out_en;
        o.step   = dp_step;
        o.pidx   = pass_idx;
        o.ov     = out_valid;
        o.err    = err_len;
        return o;
    endfunction

    // Expected outputs for cycles 0..2n+2 after the accepting edge, out_ready held high.
    function automatic void push_job(input int n, input logic [2:0] fs);
        obs_t e;
        int   k;
        for (int c = 0; c <= 2 * n + 2; c++) begin
            e = '0;
            if (c <= 2 * n + 1) begin
                e.busy = 1'b1;
                if (c > 0) begin
                    k = ((c - 1) / 2 < n - 1) ? (c - 1) / 2 : n - 1;
                    e.step = fs + 3'(k);
                end
                e.pidx = 3'((c / 2 < n - 1) ? c / 2 : n - 1);
                if ((c % 2 == 1) && (c <= 2 * n - 1)) begin
                    e.in_en  = 1'b1;
                    e.sel_fb = (c > 1);
                end
                e.out_en = (c % 2 == 0) && (c >= 2) && (c <= 2 * n);
                e.ov     = (c == 2 * n + 1);
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        start = 1'b1;
        num_passes = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        o = sample_dut();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", o, obs_t'(0));
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o = sample_dut();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", o, obs_t'(0));
        end
    endtask

    task automatic test_job(input int n, input logic [2:0] fs, input string tag);
        obs_t o, e;
        int   c;
        out_ready = 1'b1;
        start = 1'b1;
        num_passes = 4'(n);
        first_step = fs;
        push_job(n, fs);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = sample_dut();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, o, e);
            end
            c++;
        end
    endtask

    task automatic test_backpressure();
        obs_t o, e, h;
        int   c;
        out_ready = 1'b0;
        start = 1'b1;
        num_passes = 4'd1;
        first_step = 3'd5;
        push_job(1, 3'd5);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        h = '0;
        h.busy = 1'b1;
        h.step = 3'd5;
        h.ov   = 1'b1;
        repeat (10) exp_q.push_back(h);
        exp_q.push_back('0);
        exp_q.push_back('0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start = (c == 5);
            num_passes = 4'd2;
            out_ready = (c == 12);
            e = exp_q.pop_front();
            o = sample_dut();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, o, e);
            end
            c++;
        end
        start = 1'b0;
    endtask

    task automatic test_len_edges();
        obs_t o, e;
        int   c;
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            num_passes = (t == 0) ? 4'd0 : 4'd9;
            e = '0;
            if (t == 0) e.ov = 1'b1;
            else e.err = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back('0);
            c = 0;
            while (exp_q.size() > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                e = exp_q.pop_front();
                o = sample_dut();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL len_%0d cyc=%0d got=%h exp=%h", num_passes, c, o, e);
                end
                c++;
            end
        end
    endtask

    task automatic test_abort();
        obs_t o, e;
        int   c;
        out_ready = 1'b1;
        start = 1'b1;
        num_passes = 4'd4;
        first_step = 3'd1;
        push_job(4, 3'd1);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        repeat (3) exp_q.push_back('0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = sample_dut();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_eval cyc=%0d got=%h exp=%h", c, o, e);
            end
            abort = (c == 5);
            c++;
        end
        abort = 1'b1;
        start = 1'b1;
        num_passes = 4'd2;
        repeat (2) exp_q.push_back('0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
            e = exp_q.pop_front();
            o = sample_dut();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%h exp=%h", c, o, e);
            end
            c++;
        end
        test_job(2, 3'd6, "after_abort");
    endtask

    task automatic test_end_to_end();
        obs_t o;
        int   lat, bad, first_bad;
        for (int i = 0; i < SIZE; i++) ext_vec[i] = $urandom;
        for (int i = 0; i < SIZE; i++) tmp_vec[i] = ext_vec[src_idx(i, 3'd3)];
        for (int i = 0; i < SIZE; i++) exp_vec[i] = tmp_vec[src_idx(i, 3'd4)];
        out_ready = 1'b0;
        start = 1'b1;
        num_passes = 4'd2;
        first_step = 3'd3;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL e2e_latency got=%0d exp=5", lat);
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < SIZE; i++) begin
            if (dp_out[i] !== exp_vec[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL e2e_data bad_words=%0d first=%0d got=%h exp=%h", bad, first_bad,
                     dp_out[first_bad], exp_vec[first_bad]);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        num_passes = 4'd4;
        first_step = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        o = sample_dut();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", o, obs_t'(0));
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o = sample_dut();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL post_reset_idle got=%h exp=%h", o, obs_t'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_job(3, 3'd2, "basic");
        test_job(8, 3'd7, "wrap");
        test_backpressure();
        test_len_edges();
        test_abort();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
